instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Parametrised instruction fetch stage with a program counter, on-chip instruction memory, a two-entry fetch buffer and a valid/ready output handshake. It supports branch/jump redirect with buffer flush, a fetch enable, and a write port for loading the instruction memory. It sits at the front of the processor pipeline and feeds decode. Decode may stall without losing instructions.

## Interface
- `PC_W`, 16: program counter width.
- `INS_W`, 16: instruction word width.
- `ADDR_W`, 10: instruction memory index width; the depth is 2^ADDR_W words.
- `BUF_DEPTH`, 2: fetch buffer entries; must be a power of two and ≥ 2.
- `RESET_PC`, 0: PC value loaded at reset.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `fetch_en`, in, 1: fetching is allowed when high.
- `redirect_valid`, in, 1: taken branch or jump this cycle.
- `redirect_pc`, in, PC_W: redirect target.
- `imem_we`, in, 1: instruction memory write enable.
- `imem_waddr`, in, ADDR_W: write index.
- `imem_wdata`, in, INS_W: write data.
- `ins`, out, INS_W: head-of-buffer instruction.
- `ins_pc`, out, PC_W: PC of `ins`.
- `ins_valid`, out, 1: `ins` and `ins_pc` are valid.
- `ins_ready`, in, 1: the consumer accepts the instruction.
- `pc`, out, PC_W: next fetch address.

## Operation
- Memory reads are asynchronous: the current memory word is `mem[pc[ADDR_W-1:0]]`.
- Memory writes are synchronous on `imem_we`. A same-cycle read of the written index returns the old data. Memory contents are not reset.
- **pop** = `ins_valid && ins_ready`.
- **push** = `fetch_en && !redirect_valid && (count < BUF_DEPTH || pop)`.
  - On push, `{pc, mem[pc]}` enters the buffer tail and `pc` advances by 1 modulo 2^PC_W.
  - The memory index wraps modulo 2^ADDR_W.
- With no push, `pc` holds, except on redirect.
- **Redirect** (`redirect_valid=1`) has priority over everything else:
  - the buffer is flushed (count ← 0, pointers ← 0);
  - `pc` ← `redirect_pc`;
  - no push occurs;
  - `ins_valid` is forced to 0 that cycle, so no transfer can occur.
- `ins_valid = (count != 0) && !redirect_valid`. `ins` and `ins_pc` come from the buffer head. They are don't-care when `ins_valid=0`.
- Push and pop in the same cycle with a full buffer: count is unchanged and both pointers advance.
- Buffer states: EMPTY (count=0), PARTIAL, FULL (count=BUF_DEPTH).
  - PARTIAL exists only when BUF_DEPTH > 1.
  - Transitions follow the push/pop increments and decrements. Redirect returns to EMPTY from any state.
- `fetch_en=0`:
  - buffered entries still drain through the handshake;
  - a redirect is still honoured.
- The handshake must be stable: once `ins_valid=1`, `ins` and `ins_pc` hold until pop or redirect.

## Timing
- Reset (asynchronous, `reset=0`): `pc`=RESET_PC, count=0, pointers=0, `ins_valid`=0. `ins` and `ins_pc` are don't-care.
- First instruction: with `fetch_en=1`, the first rising edge after reset release pushes `mem[RESET_PC]`. `ins_valid` rises in the cycle after that edge.
- Redirect latency, with fetch enabled:
  - the redirect is sampled at edge E0;
  - `mem[redirect_pc]` is pushed at E1;
  - `ins_valid=1` with `ins_pc=redirect_pc` after E1.
  - Total: 2 cycles from redirect assertion to valid output.
- Steady state (`ins_ready=1`, no redirect): one instruction per cycle, with consecutive `ins_pc`.
- Stall (`ins_ready=0`): the buffer fills in BUF_DEPTH cycles, then `pc` freezes. Throughput resumes at one per cycle when ready returns, with no bubble.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. Buffered instructions are discarded.

## Structure
- Shared package `fetch_pkg`:
  - default widths (PC_W, INS_W, ADDR_W);
  - RESET_PC;
  - the buffer entry record type {pc, ins}.
- Sub-module `fetch_buffer`: a synchronous FIFO parametrised by width and depth.
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - Same asynchronous active-low reset.
- PC increment and memory array are in the top level.

## Test plan
- **Reset and stream:** preload mem[0..3] = 10, 11, 12, 13; release reset with `ins_ready=1`. Required: `ins_valid` rises after the first edge, then `ins` = 10, 11, 12, 13 in consecutive cycles with `ins_pc` = 0, 1, 2, 3.
- **Stall:** hold `ins_ready=0` for 5 cycles mid-stream. Required:
  - `pc` freezes after 2 pushes (BUF_DEPTH=2);
  - `ins`/`ins_pc` stay stable;
  - on release, no instruction is lost or duplicated.
- **Redirect:** pulse `redirect_valid` with `redirect_pc`=6 while the buffer is full; mem[6]=32. Required:
  - `ins_valid=0` during the pulse cycle and the next cycle;
  - then `ins`=32, `ins_pc`=6;
  - no flushed entry appears afterwards.
- **Wrap:** redirect to 2^PC_W−1 (0xFFFF). Required: `ins_pc` sequence 0xFFFF, 0x0000, and memory index 1023 then 0.
- **Memory write collision:** `imem_we` to the currently fetched index in the same cycle. Required: the old word is fetched; after a redirect back to that index, the new word is fetched.
- **Mid-run reset:** assert `reset=0` between edges. Required: `ins_valid=0` and `pc`=RESET_PC immediately, before any clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// reset PC, the fetch buffer entry record and the buffer occupancy states.
package fetch_pkg;

  localparam int unsigned FETCH_PC_W      = 16;
  localparam int unsigned FETCH_INS_W     = 16;
  localparam int unsigned FETCH_ADDR_W    = 10;
  localparam int unsigned FETCH_BUF_DEPTH = 2;
  localparam int unsigned FETCH_RESET_PC  = 0;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] ins;
  } fetch_entry_t;

  // Occupancy of the fetch buffer; PARTIAL only exists for depth > 1.
  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_PARTIAL = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO used as the fetch buffer. Occupancy is tracked by
// a count plus a registered EMPTY/PARTIAL/FULL state that drives the
// full/empty flags directly from flops. Flush empties it in one cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int unsigned WIDTH = FETCH_PC_W + FETCH_INS_W,
  parameter  int unsigned DEPTH = FETCH_BUF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  buf_state_e       state;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_nxt;

  // Occupancy state implied by a given entry count.
  function automatic buf_state_e state_of(input logic [CNT_W-1:0] c);
    if (c == '0)            return BUF_EMPTY;
    if (c == CNT_W'(DEPTH)) return BUF_FULL;
    return BUF_PARTIAL;
  endfunction

  // Guard against popping an empty buffer or overrunning a full one.
  assign do_pop  = pop && (state != BUF_EMPTY);
  assign do_push = push && ((state != BUF_FULL) || do_pop);

  // Next entry count from the push/pop pair.
  always_comb begin
    // NOTE: default assignment first so every path writes count_nxt and no latch is inferred.
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CNT_W'(1);
    else if (!do_push && do_pop) count_nxt = count - CNT_W'(1);
  end

  // Pointers, count and occupancy state; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= BUF_EMPTY;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= BUF_EMPTY;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      state <= state_of(count_nxt);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count/state guard against reading stale entries.
    if (do_push && !flush) storage[wr_ptr] <= din;
  end

  assign head  = storage[rd_ptr];
  assign full  = (state == BUF_FULL);
  assign empty = (state == BUF_EMPTY);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, asynchronously read instruction
// memory with a synchronous write port, and a small fetch buffer presenting
// {pc, instruction} to decode over a valid/ready handshake. A redirect
// flushes the buffer and reloads the PC in the same cycle.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W      = FETCH_PC_W,
  parameter int unsigned     INS_W     = FETCH_INS_W,
  parameter int unsigned     ADDR_W    = FETCH_ADDR_W,
  parameter int unsigned     BUF_DEPTH = FETCH_BUF_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [INS_W-1:0]  imem_wdata,
  output logic [INS_W-1:0]  ins,
  output logic [PC_W-1:0]   ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [PC_W-1:0]   pc
);

  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W     = $clog2(BUF_DEPTH) + 1;

  // Entry record sized by this instance's parameters.
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } entry_t;

  logic [INS_W-1:0] imem [MEM_DEPTH];
  logic [INS_W-1:0] fetch_word;
  entry_t           tail_entry;
  entry_t           head_entry;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full;
  logic             buf_empty;
  logic             pop;
  logic             push;

  // Asynchronous read; the index wraps with the low PC bits.
  assign fetch_word = imem[pc[ADDR_W-1:0]];
  assign tail_entry = '{pc: pc, ins: fetch_word};

  // Redirect hides the head for the cycle so no transfer races the flush.
  assign ins_valid = !buf_empty && !redirect_valid;
  assign pop       = ins_valid && ins_ready;
  assign push      = fetch_en && !redirect_valid && (!buf_full || pop);

  // Instruction memory write port; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // Program counter: redirect first, otherwise advance on every push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + PC_W'(1);
    end
  end

  fetch_buffer #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (tail_entry),
    .head  (head_entry),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign ins    = head_entry.ins;
  assign ins_pc = head_entry.pc;

  // Buffer flags must agree with its count and never exceed its depth.
  buf_count_consistent: assert property (
    @(posedge clk) disable iff (!reset)
      (buf_count <= CNT_W'(BUF_DEPTH)) &&
      (buf_full  == (buf_count == CNT_W'(BUF_DEPTH))) &&
      (buf_empty == (buf_count == '0))
  );

endmodule
